// File: rtl/arb_pkg.sv
// Shared types and helpers for the ring round-robin arbiter.
package arb_pkg;

  // Arbiter FSM states.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Default number of requesters.
  localparam int DEFAULT_N = 8;

  // Widest one-hot vector onehot_to_bin accepts.
  localparam int MAX_REQ = 64;

  // Binary index of the set bit in a one-hot vector.
  // OR-accumulating the indices is exact for one-hot input and yields 0
  // for an all-zero input.
  function automatic logic [31:0] onehot_to_bin(input logic [MAX_REQ-1:0] oh);
    logic [31:0] idx;
    idx = 32'd0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) begin
        idx = idx | 32'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/ring_rr_arbiter_rr_pick.sv
// Circular first-set search of req starting at the one-hot position ptr.
// The request vector is doubled: the low copy is masked to bits at or
// above ptr, the high copy is unmasked and so supplies the wrap-around.
// The lowest set bit of the doubled word is the winner; folding both
// halves back together gives the one-hot pick.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] ptr,
  output logic [N-1:0] pick
);

  localparam int W2 = 2 * N;

  logic [N-1:0]  mask_s;
  logic [W2-1:0] dbl_s;
  logic [W2-1:0] low_s;

  // Masked double-width lowest-set-bit search.
  always_comb begin
    mask_s = ~(ptr - N'(1));
    dbl_s  = {req, req & mask_s};
    low_s  = dbl_s & (~dbl_s + W2'(1));
    pick   = low_s[N-1:0] | low_s[W2-1:N];
  end

endmodule

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a one-hot ring priority pointer, hold-until-
// release grants and an optional hold timeout. All outputs are registered.
module ring_rr_arbiter
  import arb_pkg::*;
#(
  parameter int N        = DEFAULT_N,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         done,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy,
  output logic                 timeout
);

  localparam int ID_W  = $clog2(N);
  localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  arb_state_e      state_r;
  logic [N-1:0]    ptr_r;
  logic [CNT_W-1:0] cnt_r;

  logic [N-1:0]    pick_s;
  logic [ID_W-1:0] pick_id_s;
  logic            owner_done_s;
  logic            owner_req_s;
  logic            hold_expire_s;
  logic            release_s;

  rr_pick #(.N(N)) u_pick (
    .req  (req),
    .ptr  (ptr_r),
    .pick (pick_s)
  );

  // Release conditions of the current owner; grant is zero when idle so
  // non-owner done/req bits never contribute.
  always_comb begin
    pick_id_s    = ID_W'(onehot_to_bin(MAX_REQ'(pick_s)));
    owner_done_s = |(done & grant);
    owner_req_s  = |(req & grant);
    if (MAX_HOLD != 0) begin
      hold_expire_s = (cnt_r == CNT_W'(MAX_HOLD - 1));
    end else begin
      hold_expire_s = 1'b0;
    end
    release_s = owner_done_s | ~owner_req_s | hold_expire_s;
  end

  // Arbiter FSM, ring pointer, hold counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      ptr_r    <= N'(1);
      cnt_r    <= '0;
      grant    <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          timeout <= 1'b0;
          cnt_r   <= '0;
          if (|req) begin
            grant    <= pick_s;
            grant_id <= pick_id_s;
            busy     <= 1'b1;
            state_r  <= GRANT;
          end else begin
            grant    <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            state_r  <= IDLE;
          end
        end
        GRANT: begin
          if (release_s) begin
            grant    <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            ptr_r    <= {grant[N-2:0], grant[N-1]};
            cnt_r    <= '0;
            // A normal release on the same edge takes precedence.
            timeout  <= hold_expire_s & ~owner_done_s & owner_req_s;
            state_r  <= IDLE;
          end else begin
            timeout <= 1'b0;
            if (cnt_r != {CNT_W{1'b1}}) begin
              cnt_r <= cnt_r + CNT_W'(1);
            end else begin
              cnt_r <= cnt_r;
            end
          end
        end
        default: begin
          state_r  <= IDLE;
          ptr_r    <= N'(1);
          cnt_r    <= '0;
          grant    <= '0;
          grant_id <= '0;
          busy     <= 1'b0;
          timeout  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Scoreboard bench for ring_rr_arbiter: directed scenarios plus random
// traffic, checked against an index-based round-robin reference model.
module tb_ring_rr_arbiter;

  localparam int N        = 8;
  localparam int MAX_HOLD = 16;

  typedef struct packed {
    logic [N-1:0] grant;
    logic [2:0]   grant_id;
    logic         busy;
    logic         timeout;
  } exp_t;

  logic         clk;
  logic         reset;
  logic [N-1:0] req;
  logic [N-1:0] done;
  logic [N-1:0] grant;
  logic [2:0]   grant_id;
  logic         busy;
  logic         timeout;

  ring_rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .done     (done),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Reference model: owner index (-1 when idle), priority start index,
  // number of cycles the current grant has been visible.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;

  // Advance the model across the next rising edge and queue its outputs.
  task automatic model_step(input logic rst, input logic [N-1:0] r, input logic [N-1:0] d);
    exp_t e;
    bit   to;
    to = 1'b0;
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_held  = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && r[(m_ptr + k) % N]) begin
          m_owner = (m_ptr + k) % N;
          m_held  = 1;
        end
      end
    end else begin
      bit ra, rb, rc;
      ra = d[m_owner];
      rb = !r[m_owner];
      rc = (MAX_HOLD != 0) && (m_held == MAX_HOLD);
      if (ra || rb || rc) begin
        to      = rc && !ra && !rb;
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_held  = 0;
      end else begin
        m_held++;
      end
    end
    e.grant    = (m_owner < 0) ? '0 : N'(1) << m_owner;
    e.grant_id = (m_owner < 0) ? 3'd0 : 3'(m_owner);
    e.busy     = (m_owner >= 0);
    e.timeout  = to;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of stimulus on the falling edge.
  task automatic step(input logic rst, input logic [N-1:0] r, input logic [N-1:0] d);
    @(negedge clk);
    reset = rst;
    req   = r;
    done  = d;
    model_step(rst, r, d);
  endtask

  // Monitor: after each rising edge compare DUT outputs with the oldest
  // queued expectation.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++;
      if (grant !== e.grant || grant_id !== e.grant_id ||
          busy !== e.busy || timeout !== e.timeout) begin
        n_miss++;
        $display("FAIL outputs t=%0t: got grant=%h id=%0d busy=%b timeout=%b, want grant=%h id=%0d busy=%b timeout=%b",
                 $time, grant, grant_id, busy, timeout,
                 e.grant, e.grant_id, e.busy, e.timeout);
      end
      n_vec++;
      if (!$onehot(dut.ptr_r)) begin
        n_miss++;
        $display("FAIL ptr_onehot t=%0t: got ptr=%b, want exactly one bit set", $time, dut.ptr_r);
      end
    end
  end

  initial begin
    reset = 1'b1;
    req   = '0;
    done  = '0;

    // Reset, then a single requester.
    step(1'b1, 8'h00, 8'h00);
    step(1'b0, 8'h01, 8'h00);
    step(1'b0, 8'h01, 8'h00);
    step(1'b0, 8'h00, 8'h00);
    step(1'b0, 8'h00, 8'h00);

    // All requesting, owner releases via done two cycles into each grant.
    step(1'b1, 8'h00, 8'h00);
    for (int g = 0; g < 9; g++) begin
      step(1'b0, 8'hFF, 8'h00);
      step(1'b0, 8'hFF, 8'h00);
      step(1'b0, 8'hFF, 8'hFF);
    end

    // Two requesters at the ring ends alternate.
    step(1'b1, 8'h00, 8'h00);
    for (int g = 0; g < 3; g++) begin
      step(1'b0, 8'h81, 8'h00);
      step(1'b0, 8'h81, 8'h81);
    end

    // Hold without release: timeout, idle cycle, regrant.
    step(1'b1, 8'h00, 8'h00);
    for (int i = 0; i < 20; i++) step(1'b0, 8'h04, 8'h00);

    // Non-owner done ignored; owner done on the last hold cycle wins.
    step(1'b1, 8'h00, 8'h00);
    step(1'b0, 8'h02, 8'h00);
    for (int i = 1; i <= 15; i++) step(1'b0, 8'h02, (i == 3) ? 8'h08 : 8'h00);
    step(1'b0, 8'h02, 8'h02);
    step(1'b0, 8'h00, 8'h00);

    // Reset in the middle of a grant restarts the search from bit 0.
    step(1'b1, 8'h00, 8'h00);
    step(1'b0, 8'h10, 8'h00);
    step(1'b0, 8'h10, 8'h00);
    step(1'b1, 8'h10, 8'h00);
    step(1'b0, 8'h30, 8'h00);
    step(1'b0, 8'h30, 8'h00);
    step(1'b0, 8'h30, 8'h10);
    step(1'b0, 8'h30, 8'h00);
    step(1'b0, 8'h30, 8'h00);

    // Random traffic with sparse done pulses and rare resets.
    begin
      logic [N-1:0] r, d;
      logic         rst;
      r = 8'h00;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 3) == 0) r = 8'($urandom);
        d   = 8'($urandom & $urandom & $urandom);
        rst = ($urandom_range(0, 63) == 0);
        step(rst, r, d);
      end
    end

    step(1'b0, 8'h00, 8'h00);
    step(1'b0, 8'h00, 8'h00);
    @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
